// File: rtl/vga_layer_arbiter.sv
// vga_layer_arbiter: frame-aligned round-robin owner selection for up to four
// VGA layers, with OR-blended overlays and a registered 4-bit RGB output.
`default_nettype none

module vga_layer_arbiter #(
  parameter int N_LAYERS    = 4,
  parameter int HOLD_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  video_on,
  input  logic [N_LAYERS-1:0]   req,
  input  logic [N_LAYERS-1:0]   overlay_en,
  input  logic [N_LAYERS-1:0]   pix_valid,
  input  logic [4*N_LAYERS-1:0] red_in,
  input  logic [4*N_LAYERS-1:0] green_in,
  input  logic [4*N_LAYERS-1:0] blue_in,
  output logic [N_LAYERS-1:0]   grant,
  output logic [1:0]            owner_id,
  output logic                  busy,
  output logic [3:0]            red_out,
  output logic [3:0]            green_out,
  output logic [3:0]            blue_out
);

  localparam int FW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [1:0]          rr, rr_n;
  logic [FW-1:0]       fcnt, fcnt_n;
  logic [N_LAYERS-1:0] grant_n;
  logic [1:0]          owner_n;
  logic                busy_n;

  logic [2:0]          pick_res;
  logic                cand_found;
  logic [1:0]          cand;
  logic                others_req;
  logic                do_grant;

  // First requester at or after 'start', wrapping at N_LAYERS-1 -> 0.
  function automatic logic [2:0] pick(input logic [N_LAYERS-1:0] r,
                                      input logic [1:0] start);
    logic [2:0] res;
    int idx;
    res = '0;
    for (int j = N_LAYERS - 1; j >= 0; j--) begin
      idx = int'(start) + j;
      if (idx >= N_LAYERS) idx = idx - N_LAYERS;
      if (r[idx]) res = {1'b1, 2'(idx)};
    end
    return res;
  endfunction

  // The owner is always drawn; other layers only when overlaid and valid.
  function automatic logic [3:0] compose(input logic [4*N_LAYERS-1:0] ch,
                                         input logic [N_LAYERS-1:0]   draw);
    logic [3:0] res;
    res = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (draw[i]) res = res | ch[4*i +: 4];
    end
    return res;
  endfunction

  assign pick_res   = pick(req, rr);
  assign cand_found = pick_res[2];
  assign cand       = pick_res[1:0];
  assign others_req = |(req & ~grant);

  always_comb begin
    state_n  = state;
    rr_n     = rr;
    fcnt_n   = fcnt;
    grant_n  = grant;
    owner_n  = owner_id;
    busy_n   = busy;
    do_grant = 1'b0;

    if (frame_start) begin
      case (state)
        S_IDLE: begin
          if (cand_found) do_grant = 1'b1;
        end
        S_OWN: begin
          if (!req[owner_id]) begin
            if (cand_found) begin
              do_grant = 1'b1;
            end else begin
              state_n = S_IDLE;
              grant_n = '0;
              owner_n = '0;
              busy_n  = 1'b0;
            end
          end else if (others_req && (int'(fcnt) + 1 >= HOLD_FRAMES)) begin
            do_grant = 1'b1;
          end else if (int'(fcnt) < HOLD_FRAMES) begin
            fcnt_n = fcnt + FW'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    if (do_grant) begin
      state_n       = S_OWN;
      grant_n       = '0;
      grant_n[cand] = 1'b1;
      owner_n       = cand;
      busy_n        = 1'b1;
      fcnt_n        = '0;
      rr_n          = (int'(cand) == N_LAYERS - 1) ? 2'd0 : cand + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr       <= '0;
      fcnt     <= '0;
      grant    <= '0;
      owner_id <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      rr       <= rr_n;
      fcnt     <= fcnt_n;
      grant    <= grant_n;
      owner_id <= owner_n;
      busy     <= busy_n;
    end
  end

  logic [N_LAYERS-1:0] draw;
  assign draw = grant | (overlay_en & pix_valid & ~grant);

  always_ff @(posedge clk) begin
    if (!rst_n || !video_on) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else begin
      red_out   <= compose(red_in, draw);
      green_out <= compose(green_in, draw);
      blue_out  <= compose(blue_in, draw);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_layer_arbiter.sv
// Directed self-checking bench for vga_layer_arbiter (N_LAYERS=4, HOLD_FRAMES=2).
`default_nettype none

module tb_vga_layer_arbiter;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        video_on;
  logic [3:0]  req;
  logic [3:0]  overlay_en;
  logic [3:0]  pix_valid;
  logic [15:0] red_in;
  logic [15:0] green_in;
  logic [15:0] blue_in;
  logic [3:0]  grant;
  logic [1:0]  owner_id;
  logic        busy;
  logic [3:0]  red_out;
  logic [3:0]  green_out;
  logic [3:0]  blue_out;

  int n_checks = 0;
  int n_pass   = 0;

  vga_layer_arbiter #(
    .N_LAYERS    (4),
    .HOLD_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .video_on    (video_on),
    .req         (req),
    .overlay_en  (overlay_en),
    .pix_valid   (pix_valid),
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .grant       (grant),
    .owner_id    (owner_id),
    .busy        (busy),
    .red_out     (red_out),
    .green_out   (green_out),
    .blue_out    (blue_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs driven afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle frame_start pulse, then check the grant it produced.
  task automatic pulse(input string tag, input logic [3:0] exp_grant,
                       input logic [1:0] exp_owner, input int gap);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    check({tag, "_owner"}, 32'(owner_id), 32'(exp_owner));
    repeat (gap) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_owner"}, 32'(owner_id), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_rgb"},   32'({red_out, green_out, blue_out}), 32'h0);
  endtask

  logic [3:0] rot_exp [6];

  initial begin
    rot_exp = '{4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0001};

    // Reset with random inputs
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      frame_start = 1'($urandom);
      video_on    = 1'($urandom);
      req         = 4'($urandom);
      overlay_en  = 4'($urandom);
      pix_valid   = 4'($urandom);
      red_in      = 16'($urandom);
      green_in    = 16'($urandom);
      blue_in     = 16'($urandom);
      step();
    end
    check_all_zero("reset");

    // Idle blending: only the overlay layer is drawn
    rst_n       = 1'b1;
    frame_start = 1'b0;
    video_on    = 1'b1;
    req         = 4'b0000;
    overlay_en  = 4'b0001;
    pix_valid   = 4'b0001;
    red_in      = 16'hA905;
    green_in    = 16'h0000;
    blue_in     = 16'h0000;
    step();
    check("idle_red", 32'(red_out), 32'h5);
    check("idle_busy", 32'(busy), 32'h0);

    // Frame-aligned grant of layer 2
    overlay_en = 4'b0000;
    req        = 4'b0100;
    step();
    check("midframe_grant0", 32'(grant), 32'h0);
    step();
    check("midframe_grant1", 32'(grant), 32'h0);
    pulse("fs_grant2", 4'b0100, 2'd2, 0);
    check("fs_busy", 32'(busy), 32'h1);
    check("fs_pix_old_owner", 32'(red_out), 32'h0);
    step();
    check("owner2_red", 32'(red_out), 32'h9);

    // Hand ownership to layer 0 (search from rr=3 wraps to 0), then rotate
    req = 4'b0001;
    pulse("to_layer0", 4'b0001, 2'd0, 2);
    req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] eo;
      eo = (rot_exp[k] == 4'b0001) ? 2'd0 : (rot_exp[k] == 4'b0010) ? 2'd1 : 2'd3;
      pulse($sformatf("rot%0d", k), rot_exp[k], eo, (k == 3) ? 0 : 2);
    end

    // Release to layer 1, blue overlay blending
    req = 4'b0010;
    pulse("to_layer1", 4'b0010, 2'd1, 0);
    red_in     = 16'h0000;
    blue_in    = 16'h3080;
    overlay_en = 4'b1000;
    pix_valid  = 4'b1000;
    step();
    check("blend_blue", 32'(blue_out), 32'hB);
    req = 4'b0000;
    step();
    check("release_hold_grant", 32'(grant), 32'h2);
    check("release_hold_blue", 32'(blue_out), 32'hB);
    pulse("release_idle", 4'b0000, 2'd0, 0);
    check("release_busy", 32'(busy), 32'h0);
    step();
    check("idle_ovl_blue", 32'(blue_out), 32'h3);

    // Blanking forces black
    video_on   = 1'b0;
    red_in     = 16'hFFFF;
    green_in   = 16'hFFFF;
    blue_in    = 16'hFFFF;
    overlay_en = 4'b1111;
    pix_valid  = 4'b1111;
    step();
    check("blank_rgb", 32'({red_out, green_out, blue_out}), 32'h0);

    // Mid-frame reset during active video
    req = 4'b0001;
    pulse("pre_rst_grant", 4'b0001, 2'd0, 0);
    video_on = 1'b1;
    step();
    check("active_red", 32'(red_out), 32'hF);
    rst_n = 1'b0;
    step();
    check_all_zero("midrst");

    // Reset wins over frame_start in the same cycle
    frame_start = 1'b1;
    step();
    check("rst_vs_fs_grant", 32'(grant), 32'h0);
    rst_n       = 1'b1;
    frame_start = 1'b0;
    step();
    check("idle_no_fs_grant", 32'(grant), 32'h0);

    // req change coincident with frame_start is the value arbitrated
    req = 4'b0100;
    pulse("same_cycle_req", 4'b0100, 2'd2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
